lsu_stall_unit: RTL

- Load-store unit between the core's memory stage and the data-memory address decoder.
- Converts core load/store requests (byte/half/word, signed/unsigned) into word-aligned memory requests with byte enables and lane-replicated write data.
- Stalls the core for exactly one cycle per access while the synchronous data memory or the LED port responds.
- Sign/zero-extends the returned read data.

---
 rtl/lsu_stall_unit_if.sv | 64 ++++++
 rtl/lsu_stall_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_stall_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_stall_unit_if
//  Description : Core-side and memory-side signal bundle of the load-store
//                unit. The unit itself takes the slave view, and the core
//                plus memory model take the master view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_stall_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    // Core side
    logic                  lsu_req_i;
    logic                  lsu_we_i;
    logic [2:0]            lsu_size_i;
    logic [ADDR_WIDTH-1:0] lsu_addr_i;
    logic [31:0]           lsu_wdata_i;
    logic [31:0]           lsu_rdata_o;
    logic                  lsu_stall_o;
    logic                  lsu_misalign_o;

    // Memory / address-decoder side
    logic                  data_req_o;
    logic                  data_we_o;
    logic [3:0]            data_be_o;
    logic [ADDR_WIDTH-1:0] data_addr_o;
    logic [31:0]           data_wdata_o;
    logic [31:0]           data_rdata_i;

    modport slave (
        input  lsu_req_i,
        input  lsu_we_i,
        input  lsu_size_i,
        input  lsu_addr_i,
        input  lsu_wdata_i,
        output lsu_rdata_o,
        output lsu_stall_o,
        output lsu_misalign_o,
        output data_req_o,
        output data_we_o,
        output data_be_o,
        output data_addr_o,
        output data_wdata_o,
        input  data_rdata_i
    );

    modport master (
        output lsu_req_i,
        output lsu_we_i,
        output lsu_size_i,
        output lsu_addr_i,
        output lsu_wdata_i,
        input  lsu_rdata_o,
        input  lsu_stall_o,
        input  lsu_misalign_o,
        input  data_req_o,
        input  data_we_o,
        input  data_be_o,
        input  data_addr_o,
        input  data_wdata_o,
        output data_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/lsu_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_stall_unit
//  Description : Converts core byte/half/word loads and stores into
//                word-aligned memory requests, stalling the core for one
//                cycle per access and extending the returned read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_stall_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    lsu_stall_unit_if.slave   bus
);

    // RISC-V funct3 access sizes
    localparam logic [2:0] c_SZ_B  = 3'd0;
    localparam logic [2:0] c_SZ_H  = 3'd1;
    localparam logic [2:0] c_SZ_W  = 3'd2;
    localparam logic [2:0] c_SZ_BU = 3'd4;
    localparam logic [2:0] c_SZ_HU = 3'd5;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [1:0] r_offset;
    logic [2:0] r_size;
    logic       r_we;

    logic                  w_illegal;
    logic                  w_accept;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata_rep;
    logic [31:0]           w_load_data;
    logic [7:0]            w_byte_lane;
    logic [15:0]           w_half_lane;
    logic [ADDR_WIDTH-1:0] w_addr_aligned;

    logic                  w_req;
    logic                  w_we;
    logic                  w_stall;
    logic                  w_misalign;
    logic [3:0]            w_be_out;
    logic [ADDR_WIDTH-1:0] w_addr_out;
    logic [31:0]           w_wdata_out;
    logic [31:0]           w_rdata_out;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        w_illegal = 1'b0;
        case (bus.lsu_size_i)
            c_SZ_B, c_SZ_BU: w_illegal = 1'b0;
            c_SZ_H, c_SZ_HU: w_illegal = bus.lsu_addr_i[0];
            c_SZ_W:          w_illegal = (bus.lsu_addr_i[1:0] != 2'b00);
            default:         w_illegal = 1'b1;
        endcase
    end

    assign w_accept       = (r_state == c_ST_IDLE) && bus.lsu_req_i && !w_illegal;
    assign w_addr_aligned = {bus.lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        w_be        = 4'b0000;
        w_wdata_rep = 32'd0;
        case (bus.lsu_size_i)
            c_SZ_B, c_SZ_BU: begin
                w_be        = 4'b0001 << bus.lsu_addr_i[1:0];
                w_wdata_rep = {4{bus.lsu_wdata_i[7:0]}};
            end
            c_SZ_H, c_SZ_HU: begin
                w_be        = bus.lsu_addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{bus.lsu_wdata_i[15:0]}};
            end
            c_SZ_W: begin
                w_be        = 4'b1111;
                w_wdata_rep = bus.lsu_wdata_i;
            end
            default: begin
                w_be        = 4'b0000;
                w_wdata_rep = 32'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction from the latched offset and size
    // ------------------------------------------------------------------
    always_comb begin
        w_byte_lane = 8'd0;
        case (r_offset)
            2'd0: w_byte_lane = bus.data_rdata_i[7:0];
            2'd1: w_byte_lane = bus.data_rdata_i[15:8];
            2'd2: w_byte_lane = bus.data_rdata_i[23:16];
            2'd3: w_byte_lane = bus.data_rdata_i[31:24];
            default: w_byte_lane = 8'd0;
        endcase
    end

    assign w_half_lane = r_offset[1] ? bus.data_rdata_i[31:16] : bus.data_rdata_i[15:0];

    always_comb begin
        w_load_data = 32'd0;
        case (r_size)
            c_SZ_B:  w_load_data = {{24{w_byte_lane[7]}}, w_byte_lane};
            c_SZ_BU: w_load_data = {24'd0, w_byte_lane};
            c_SZ_H:  w_load_data = {{16{w_half_lane[15]}}, w_half_lane};
            c_SZ_HU: w_load_data = {16'd0, w_half_lane};
            c_SZ_W:  w_load_data = bus.data_rdata_i;
            default: w_load_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register (with access context latch)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= c_ST_IDLE;
            r_offset <= 2'd0;
            r_size   <= 3'd0;
            r_we     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_offset <= bus.lsu_addr_i[1:0];
                r_size   <= bus.lsu_size_i;
                r_we     <= bus.lsu_we_i;
            end
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: w_state_nxt = w_accept ? c_ST_WAIT : c_ST_IDLE;
            c_ST_WAIT: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // FSM: outputs. In WAIT the core still holds its request, so it is ignored.
    always_comb begin
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_stall     = 1'b0;
        w_misalign  = 1'b0;
        w_be_out    = 4'b0000;
        w_addr_out  = '0;
        w_wdata_out = 32'd0;
        w_rdata_out = 32'd0;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.lsu_req_i) begin
                    if (w_illegal) begin
                        w_misalign = 1'b1;
                    end else begin
                        w_req       = 1'b1;
                        w_we        = bus.lsu_we_i;
                        w_stall     = 1'b1;
                        w_be_out    = w_be;
                        w_addr_out  = w_addr_aligned;
                        w_wdata_out = bus.lsu_we_i ? w_wdata_rep : 32'd0;
                    end
                end
            end
            c_ST_WAIT: begin
                if (!r_we) begin
                    w_rdata_out = w_load_data;
                end
            end
            default: begin
                w_req = 1'b0;
            end
        endcase
    end

    assign bus.data_req_o     = w_req;
    assign bus.data_we_o      = w_we;
    assign bus.data_be_o      = w_be_out;
    assign bus.data_addr_o    = w_addr_out;
    assign bus.data_wdata_o   = w_wdata_out;
    assign bus.lsu_stall_o    = w_stall;
    assign bus.lsu_misalign_o = w_misalign;
    assign bus.lsu_rdata_o    = w_rdata_out;

endmodule
`default_nettype wire
